if_pc_unit: RTL and testbench

- Instruction-fetch and program-counter stage that sits directly upstream of the control unit.
- Holds the PC, fetches one 32-bit instruction per step from instruction memory over a req/valid handshake, and presents the decoded fields (op, func, rs, rt, rd, shamt, imm, target) to the control unit and the datapath.
- Consumes the control unit's 2-bit Branch select to compute the next PC.
- Supplies PC+4 for jal link writeback when PCtoReg is set.

---
 rtl/if_pc_unit_pkg.sv | 39 +++
 rtl/if_next_pc.sv | 29 ++
 rtl/if_pc_unit.sv | 136 +++++++++++++
 tb/tb_if_pc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch / PC stage: branch selects,
// FSM encoding, reset/exception addresses and instruction field positions.
package if_pc_unit_pkg;

  localparam logic [1:0] BR_SEQ   = 2'b00;
  localparam logic [1:0] BR_TAKEN = 2'b01;
  localparam logic [1:0] BR_JUMP  = 2'b10;
  localparam logic [1:0] BR_JR    = 2'b11;

  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_MSB   = 15;
  localparam int TGT_MSB   = 25;

  // Word-aligned branch displacement from a 16-bit immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch,
// pseudo-direct jump, or register-indirect jump.
module if_next_pc
  import if_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  branch,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  // Select the raw next PC; alignment handling is left to the caller.
  always_comb begin
    next_pc = pc_plus4;
    case (branch)
      BR_SEQ:   next_pc = pc_plus4;
      BR_TAKEN: next_pc = pc_plus4 + branch_offset(imm16);
      BR_JUMP:  next_pc = {pc_plus4[31:28], target26, 2'b00};
      BR_JR:    next_pc = jr_target;
      default:  next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_pc_unit.sv
// Instruction-fetch and PC stage. Optional misaligned-PC trap is enabled by
// defining IF_MISALIGN_TRAP_EN; otherwise the low PC bits are dropped.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic [1:0]  branch,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exc
);

  state_t      state;
  state_t      state_next;
  logic        fetch_take;
  logic        commit;
  logic        trap;
  logic        exc_pulse;
  logic [31:0] raw_next_pc;
  logic [31:0] commit_pc;

  assign op       = instr[OP_MSB:OP_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign shamt    = instr[SHAMT_MSB:SHAMT_LSB];
  assign func     = instr[FUNC_MSB:FUNC_LSB];
  assign imm16    = instr[IMM_MSB:0];
  assign target26 = instr[TGT_MSB:0];
  assign imem_addr = pc;
  assign exc       = exc_pulse;

  if_next_pc u_next_pc (
    .pc        (pc),
    .branch    (branch),
    .imm16     (instr[IMM_MSB:0]),
    .target26  (instr[TGT_MSB:0]),
    .jr_target (jr_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (raw_next_pc)
  );

  // Alignment policy applied to the committed PC.
  always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
    trap      = (raw_next_pc[1:0] != 2'b00);
    commit_pc = trap ? EXC_VECTOR : raw_next_pc;
`else
    trap      = 1'b0;
    commit_pc = {raw_next_pc[31:2], 2'b00};
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; a valid without a request is ignored.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    fetch_take = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_RST: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          fetch_take = 1'b1;
          state_next = ST_EXEC;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          commit     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_EXEC;
        end
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  // PC, instruction register and trap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      exc_pulse   <= 1'b0;
    end else begin
      exc_pulse <= 1'b0;
      if (fetch_take) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end else if (commit) begin
        pc          <= commit_pc;
        instr_valid <= 1'b0;
        exc_pulse   <= trap;
      end
    end
  end

endmodule

// File: tb/tb_if_pc_unit.sv
// Self-checking bench for if_pc_unit: directed vector table, multi-cycle
// reset corner cases and randomized instructions against a reference model.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic [1:0]  branch;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] word;
    int          lat;
    logic [1:0]  br;
    logic [31:0] jr;
    int          nstall;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  if_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .branch(branch), .jr_target(jr_target), .instr(instr),
    .instr_valid(instr_valid), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .func(func), .imm16(imm16), .target26(target26),
    .pc(pc), .pc_plus4(pc_plus4), .exc(exc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, using signed arithmetic.
  function automatic logic [31:0] ref_raw(input logic [31:0] cur, input logic [31:0] word,
                                          input logic [1:0] br, input logic [31:0] jr);
    logic [15:0] imm;
    int          off;
    logic [31:0] seq;
    seq = cur + 32'd4;
    imm = word[15:0];
    off = int'($signed(imm)) * 4;
    case (br)
      2'd0:    return seq;
      2'd1:    return seq + 32'(off);
      2'd2:    return (seq & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
      default: return jr;
    endcase
  endfunction

  function automatic bit ref_trap(input logic [31:0] raw);
`ifdef IF_MISALIGN_TRAP_EN
    return (raw % 32'd4) != 32'd0;
`else
    return 1'b0 && raw[0];
`endif
  endfunction

  function automatic logic [31:0] ref_commit(input logic [31:0] raw);
`ifdef IF_MISALIGN_TRAP_EN
    return ref_trap(raw) ? 32'h0000_0080 : raw;
`else
    return raw - (raw % 32'd4);
`endif
  endfunction

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
  endtask

  task automatic run_instr(input vec_t v, input bit use_want);
    logic [31:0] raw;
    bit          trap;
    wait_req();
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_valid_low", 32'(instr_valid), 32'd0);
    for (int i = 0; i < v.lat; i++) begin
      imem_rdata = $urandom;
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, exp_pc);
    end
    imem_valid = 1'b1;
    imem_rdata = v.word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    chk("instr", instr, v.word);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("exec_req_low", 32'(imem_req), 32'd0);
    chk("op", 32'(op), 32'(v.word >> 26));
    chk("rs", 32'(rs), (v.word >> 21) & 32'h1F);
    chk("rt", 32'(rt), (v.word >> 16) & 32'h1F);
    chk("rd", 32'(rd), (v.word >> 11) & 32'h1F);
    chk("shamt", 32'(shamt), (v.word >> 6) & 32'h1F);
    chk("func", 32'(func), v.word & 32'h3F);
    chk("imm16", 32'(imm16), v.word & 32'hFFFF);
    chk("target26", 32'(target26), v.word & 32'h03FF_FFFF);
    chk("exec_pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("exc_idle", 32'(exc), 32'd0);
    for (int i = 0; i < v.nstall; i++) begin
      stall     = 1'b1;
      branch    = 2'($urandom_range(3, 0));
      jr_target = $urandom;
      @(negedge clk);
      chk("stall_req_low", 32'(imem_req), 32'd0);
      chk("stall_pc", pc, exp_pc);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall     = 1'b0;
    branch    = v.br;
    jr_target = v.jr;
    @(negedge clk);
    branch    = 2'($urandom_range(3, 0));
    raw    = ref_raw(exp_pc, v.word, v.br, v.jr);
    trap   = ref_trap(raw);
    exp_pc = ref_commit(raw);
    if (use_want) chk("table_next_pc", pc, v.want);
    chk("next_pc", pc, exp_pc);
    chk("commit_valid_low", 32'(instr_valid), 32'd0);
    chk("exc_pulse", 32'(exc), 32'(trap));
    chk("refetch_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0; imem_rdata = 32'h0; imem_valid = 1'b0;
    stall = 1'b0; branch = 2'b00; jr_target = 32'h0;
    vecs[0]  = '{32'h2008_0005, 3, 2'd0, 32'h0,         0, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0000, 0, 2'd3, 32'h40,        0, 32'h0000_0040};
    vecs[2]  = '{32'h1000_FFFE, 0, 2'd1, 32'h0,         0, 32'h0000_003C};
    vecs[3]  = '{32'h0000_0000, 1, 2'd3, 32'h40,        0, 32'h0000_0040};
    vecs[4]  = '{32'h1000_0003, 0, 2'd1, 32'h0,         0, 32'h0000_0050};
    vecs[5]  = '{32'h0000_0000, 0, 2'd3, 32'h1000_0010, 0, 32'h1000_0010};
    vecs[6]  = '{32'h0800_0100, 1, 2'd2, 32'h0,         0, 32'h1000_0400};
    vecs[7]  = '{32'h03E0_0008, 0, 2'd3, 32'h200,       4, 32'h0000_0200};
    vecs[8]  = '{32'h0000_0000, 0, 2'd3, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC};
    vecs[9]  = '{32'h0000_0000, 2, 2'd0, 32'h0,         0, 32'h0000_0000};
`ifdef IF_MISALIGN_TRAP_EN
    vecs[10] = '{32'h03E0_0008, 0, 2'd3, 32'h203,       0, 32'h0000_0080};
`else
    vecs[10] = '{32'h03E0_0008, 0, 2'd3, 32'h203,       0, 32'h0000_0200};
`endif
    vecs[11] = '{32'h2008_0005, 2, 2'd0, 32'h0,         0, 32'h0000_0000};
    // Fixing the last expectation from its predecessor keeps the table self-contained.
    vecs[11].want = vecs[10].want + 32'd4;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    @(negedge clk);
    chk("req_after_rst", 32'(imem_req), 32'd1);

    for (int i = 0; i < 12; i++) run_instr(vecs[i], 1'b1);

    // Reset mid-fetch with data valid: data must be dropped.
    wait_req();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    @(negedge clk);
    chk("midrst_refetch_req", 32'(imem_req), 32'd1);
    chk("midrst_refetch_addr", imem_addr, 32'h0);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv.word   = $urandom;
      rv.lat    = int'($urandom_range(3, 0));
      rv.br     = 2'($urandom_range(3, 0));
      rv.jr     = $urandom;
      rv.nstall = int'($urandom_range(2, 0));
      rv.want   = 32'h0;
      run_instr(rv, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
